serial_full_adder_module: RTL
=============================

# serial_full_adder_module

Parametrised bit-serial adder built around one full-adder slice and a carry flip-flop. Adds two WIDTH-bit operands LSB-first, one bit per clock, under a start/busy/done handshake, and reports sum, carry-out and signed overflow. It is the area-lean multi-bit successor to the combinational 1-bit full adder, for datapaths where latency is cheaper than a WIDTH-wide ripple chain.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- cin  input  1  carry-in, captured on an accepted start.
- sub  input  1  subtract select, captured on an accepted start (present only with SERIAL_ADDER_SUB_EN).
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: result valid.
- sum  output  WIDTH  registered result.
- cout  output  1  carry out of bit WIDTH-1.
- overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB).

## Operation
- One clock; reset is synchronous and active-high.
- States: IDLE, RUN, DONE. Bit counter of $clog2(WIDTH) bits.
- IDLE: busy=0, done=0. start=1 -> load shift registers with a, b; carry FF <- cin; counter <- 0; go RUN.
- RUN: busy=1. Each cycle: s = a_sh[0]^b_sh[0]^c; c <- majority(a_sh[0], b_sh[0], c); s shifted into internal result register from the MSB end; a_sh, b_sh shift right; counter +1. At counter = WIDTH-2 also record carry-into-MSB. After the counter reaches WIDTH-1, go DONE.
- DONE: done=1, busy=0; sum, cout, overflow updated with the completed result on entry to DONE. start=1 here is accepted exactly as in IDLE (go RUN); otherwise go IDLE.
- sum/cout/overflow hold their value until the next completed operation; they are not disturbed while RUN is in progress.
- start while busy=1: ignored, operands unchanged.
- Arithmetic is modulo 2^WIDTH; cout is the true bit WIDTH of a+b+cin.
- Reset (any state, incl. mid-RUN): state IDLE; busy=0, done=0, sum=0, cout=0, overflow=0; shift registers, carry FF, counter cleared; no done pulse for the aborted operation.

## Timing
- start high in cycle k (accepted) -> busy high cycles k+1..k+WIDTH -> done high in cycle k+WIDTH+1, result outputs valid from that cycle on.
- Latency: WIDTH+1 cycles start-to-done; throughput one operation per WIDTH+1 cycles with start held in the done cycle.
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- SERIAL_ADDER_SUB_EN defined: sub port exists; sub=1 captures ~b in place of b and forces initial carry to 1 (cin ignored), computing a-b; cout=1 means no borrow; overflow is signed subtraction overflow.
- Not defined: no sub port; block always adds a+b+cin.

## Test plan
- WIDTH=8, reset, then start with a=8'h3C, b=8'h05, cin=0 in cycle k -> busy k+1..k+8, done pulse at k+9, sum=8'h41, cout=0, overflow=0.
- a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1, overflow=0; then a=8'h7F, b=8'h00, cin=1 -> sum=8'h80, cout=0, overflow=1.
- start pulsed again at k+3 with a=8'h11 during busy -> ignored; done at k+9 still reports the first operation's result.
- Reset asserted in cycle k+4 of a run -> busy=0, sum=0, cout=0, overflow=0 next cycle; no done pulse appears through k+12.
- start held high through the done cycle with new operands a=8'h01, b=8'h02 -> second done exactly 9 cycles after the first, sum=8'h03.
- SERIAL_ADDER_SUB_EN defined: a=8'h05, b=8'h07, sub=1 -> sum=8'hFE, cout=0; a=8'h80, b=8'h01, sub=1 -> sum=8'h7F, overflow=1.

Source files
------------

// File: rtl/serial_full_adder_module.sv
// ============================================================================
// Module  : serial_full_adder_module
// Brief   : Bit-serial WIDTH-bit adder (LSB first, one bit per clock) with
//           start/busy/done handshake, carry-out and signed overflow.
//           Optional subtract mode enabled by defining SERIAL_ADDER_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_full_adder_module #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int                c_CW     = $clog2(WIDTH);
    localparam logic [c_CW-1:0]   c_LAST   = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0]   c_PENULT = c_CW'(WIDTH - 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [WIDTH-1:0]  r_a_sh;
    logic [WIDTH-1:0]  r_b_sh;
    logic [WIDTH-1:0]  r_res;
    logic              r_carry;
    logic              r_carry_msb;
    logic [c_CW-1:0]   r_cnt;

    logic              r_busy;
    logic              r_done;
    logic [WIDTH-1:0]  r_sum;
    logic              r_cout;
    logic              r_overflow;

    logic              w_load;
    logic              w_last;
    logic              w_s;
    logic              w_c_next;
    logic [WIDTH-1:0]  w_b_load;
    logic              w_c_load;

    // Subtraction is a + ~b + 1, so only the loaded B and initial carry change
`ifdef SERIAL_ADDER_SUB_EN
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub ? 1'b1 : cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    assign w_load   = start && (r_state != ST_RUN);
    assign w_last   = (r_cnt == c_LAST);
    assign w_s      = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
    assign w_c_next = (r_a_sh[0] & r_b_sh[0]) |
                      (r_a_sh[0] & r_carry)   |
                      (r_b_sh[0] & r_carry);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last) w_state_next = ST_DONE;
            ST_DONE: w_state_next = start ? ST_RUN : ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they leave a flop directly
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_res       <= '0;
            r_carry     <= 1'b0;
            r_carry_msb <= 1'b0;
            r_cnt       <= '0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_overflow  <= 1'b0;
        end else if (w_load) begin
            r_a_sh      <= a;
            r_b_sh      <= w_b_load;
            r_res       <= '0;
            r_carry     <= w_c_load;
            r_carry_msb <= 1'b0;
            r_cnt       <= '0;
        end else if (r_state == ST_RUN) begin
            r_a_sh  <= {1'b0, r_a_sh[WIDTH-1:1]};
            r_b_sh  <= {1'b0, r_b_sh[WIDTH-1:1]};
            r_res   <= {w_s, r_res[WIDTH-1:1]};
            r_carry <= w_c_next;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == c_PENULT) begin
                r_carry_msb <= w_c_next;
            end
            // Publish the finished result only on entry to DONE
            if (w_last) begin
                r_sum      <= {w_s, r_res[WIDTH-1:1]};
                r_cout     <= w_c_next;
                r_overflow <= w_c_next ^ r_carry_msb;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign sum      = r_sum;
    assign cout     = r_cout;
    assign overflow = r_overflow;

endmodule

`default_nettype wire
